// File: rtl/driver_pkg.sv
// driver_pkg: shared constants, FSM state type and the
// RGB888 -> 48-bit grayscale expansion for the driver serializer.
package driver_pkg;

    localparam int NB_DRIVERS    = 16;
    localparam int PIXEL_W       = 24;
    localparam int GS_W          = 48;
    localparam int WORDS_PER_SEQ = 16;

    localparam int BIT_W  = 6;
    localparam int WORD_W = 4;

    localparam logic [BIT_W-1:0]  LAST_BIT   = BIT_W'(GS_W - 1);
    localparam logic [WORD_W-1:0] LAST_WORD  = WORD_W'(WORDS_PER_SEQ - 1);
    // lat spans one SCLK edge (WRTGS) or three edges (LATGS)
    localparam logic [BIT_W-1:0]  WRTGS_BITS = BIT_W'(1);
    localparam logic [BIT_W-1:0]  LATGS_BITS = BIT_W'(3);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        NEXT  = 2'd3
    } ser_state_t;

    // Each 8-bit channel is replicated to 16 bits: {R16, G16, B16}
    function automatic logic [GS_W-1:0] gs_expand(
        input logic [PIXEL_W-1:0] rgb
    );
        return {rgb[23:16], rgb[23:16],
                rgb[15:8],  rgb[15:8],
                rgb[7:0],   rgb[7:0]};
    endfunction

endpackage

// File: rtl/gs_lane.sv
// gs_lane: one driver lane, a 48-bit MSB-first shift register.
// sin is the register MSB, so it is a registered output.
module gs_lane
    import driver_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            load,
    input  logic            shift,
    input  logic [GS_W-1:0] gs,
    output logic            sin
);

    logic [GS_W-1:0] shreg;

    // Clear wins over load, load over shift; zeros fill from the LSB
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg <= '0;
        end else if (clr) begin
            shreg <= '0;
        end else if (load) begin
            shreg <= gs;
        end else if (shift) begin
            shreg <= {shreg[GS_W-2:0], 1'b0};
        end
    end

    assign sin = shreg[GS_W-1];

endmodule

// File: rtl/driver_serializer.sv
// driver_serializer: latches a 16-lane column word, shifts it out
// on parallel SIN lanes with SCLK/LAT, and pulses EOC per word.
module driver_serializer
    import driver_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clk_enable,
    input  logic                          SOF,
    input  logic                          driver_SOF,
    input  logic [NB_DRIVERS*PIXEL_W-1:0] data_in,
    output logic                          EOC,
    output logic                          sclk,
    output logic [NB_DRIVERS-1:0]         sin,
    output logic                          lat,
    output logic                          busy
);

    ser_state_t        state, state_n;
    logic [BIT_W-1:0]  bit_cnt, bit_n;
    logic [WORD_W-1:0] word_cnt, word_n;
    logic              phase, phase_n;

    logic              eoc_n, sclk_n, lat_n, busy_n;
    logic [BIT_W-1:0]  lat_lim;
    logic              lane_load, lane_shift;

    // Next state and counters; SOF overrides everything, even when disabled
    always_comb begin
        state_n = state;
        bit_n   = bit_cnt;
        word_n  = word_cnt;
        phase_n = phase;
        if (SOF) begin
            state_n = IDLE;
            bit_n   = '0;
            word_n  = '0;
            phase_n = 1'b0;
        end else if (clk_enable) begin
            unique case (state)
                IDLE: begin
                    if (driver_SOF) begin
                        state_n = LOAD;
                        word_n  = '0;
                    end
                end
                LOAD: begin
                    state_n = SHIFT;
                    bit_n   = '0;
                    phase_n = 1'b0;
                end
                SHIFT: begin
                    if (!phase) begin
                        phase_n = 1'b1;
                    end else begin
                        phase_n = 1'b0;
                        if (bit_cnt == LAST_BIT) begin
                            state_n = NEXT;
                        end else begin
                            bit_n = bit_cnt + 1'b1;
                        end
                    end
                end
                NEXT: begin
                    if (word_cnt == LAST_WORD) begin
                        state_n = IDLE;
                        word_n  = '0;
                    end else begin
                        state_n = LOAD;
                        word_n  = word_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    // Outputs follow the upcoming state so they line up with it cycle-for-cycle
    always_comb begin
        lat_lim = (word_n == LAST_WORD) ? LATGS_BITS : WRTGS_BITS;
        eoc_n   = (state_n == NEXT);
        sclk_n  = (state_n == SHIFT) && phase_n;
        lat_n   = (state_n == SHIFT) && (bit_n < lat_lim);
        busy_n  = (state_n != IDLE);
    end

    // State and counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            word_cnt <= '0;
            phase    <= 1'b0;
        end else begin
            state    <= state_n;
            bit_cnt  <= bit_n;
            word_cnt <= word_n;
            phase    <= phase_n;
        end
    end

    // Registered control outputs; they hold whenever the state holds
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            EOC  <= 1'b0;
            sclk <= 1'b0;
            lat  <= 1'b0;
            busy <= 1'b0;
        end else begin
            EOC  <= eoc_n;
            sclk <= sclk_n;
            lat  <= lat_n;
            busy <= busy_n;
        end
    end

    // Lanes capture in LOAD and shift at the end of each SCLK-high cycle
    assign lane_load  = clk_enable && !SOF && (state == LOAD);
    assign lane_shift = clk_enable && !SOF && (state == SHIFT) && phase;

    for (genvar d = 0; d < NB_DRIVERS; d++) begin : g_lane
        logic [GS_W-1:0] gs;
        assign gs = gs_expand(data_in[PIXEL_W*d +: PIXEL_W]);

        gs_lane u_lane (
            .clk   (clk),
            .rst   (rst),
            .clr   (SOF),
            .load  (lane_load),
            .shift (lane_shift),
            .gs    (gs),
            .sin   (sin[d])
        );
    end

endmodule
